// File: rtl/rejestr_pkg.sv
// Shared types and defaults for the universal shift register.
package rejestr_pkg;

  localparam int unsigned DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

endpackage

// File: rtl/rejestr_przesuwajacy.sv
// Universal shift register (74194-style): hold, shift right, shift left, parallel load.
// Q comes straight from the flops; the fill bit enters at the vacated end on either shift.
module rejestr_przesuwajacy
  import rejestr_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter logic        FILL  = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             S0,
  input  logic             S1,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  mode_e            mode;

  assign mode = mode_e'({S1, S0});

  // Next-state selection; shifts never wrap, so repeated shifts drain to all-FILL.
  always_comb begin
    q_d = q_q;
    case (mode)
      MODE_HOLD: q_d = q_q;
      MODE_SHR:  q_d = {FILL, q_q[WIDTH-1:1]};
      MODE_SHL:  q_d = {q_q[WIDTH-2:0], FILL};
      MODE_LOAD: q_d = I;
      default:   q_d = q_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

`ifndef SYNTHESIS
  // Simulation-only sanity checks on width and mode inputs.
  always @(posedge CLK) begin
    if (RST) begin
      assert (!$isunknown({S1, S0}))
        else $error("rejestr_przesuwajacy: unknown mode select");
      assert (WIDTH >= 2 && WIDTH <= 64)
        else $error("rejestr_przesuwajacy: WIDTH out of range");
    end
  end
`endif

endmodule

// File: tb/tb_rejestr_przesuwajacy.sv
// Directed self-checking bench for rejestr_przesuwajacy (4-bit fill-0 and 8-bit fill-1 instances).
module tb_rejestr_przesuwajacy;

  logic       clk;
  logic       rst4, s0_4, s1_4;
  logic [3:0] i4, q4;
  logic       rst8, s0_8, s1_8;
  logic [7:0] i8, q8;

  int checks;
  int failures;

  rejestr_przesuwajacy #(.WIDTH(4), .FILL(1'b0)) dut4 (
    .CLK(clk), .RST(rst4), .S0(s0_4), .S1(s1_4), .I(i4), .Q(q4)
  );

  rejestr_przesuwajacy #(.WIDTH(8), .FILL(1'b1)) dut8 (
    .CLK(clk), .RST(rst8), .S0(s0_8), .S1(s1_8), .I(i8), .Q(q8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0] mode;
    logic [3:0] din;
    logic [3:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply mode/data at the falling edge, sample 1 time unit after the rising edge.
  task automatic step4(input logic [1:0] mode, input logic [3:0] din);
    @(negedge clk);
    {s1_4, s0_4} = mode;
    i4 = din;
    @(posedge clk);
    #1;
  endtask

  task automatic step8(input logic [1:0] mode, input logic [7:0] din);
    @(negedge clk);
    {s1_8, s0_8} = mode;
    i8 = din;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[16];
  logic [7:0] exp8[12];

  initial begin
    checks   = 0;
    failures = 0;
    rst4 = 1'b0; s0_4 = 1'b0; s1_4 = 1'b0; i4 = 4'h0;
    rst8 = 1'b0; s0_8 = 1'b0; s1_8 = 1'b0; i8 = 8'h00;

    vecs[0]  = '{2'b11, 4'b1010, 4'b1010};
    vecs[1]  = '{2'b00, 4'b1111, 4'b1010};
    vecs[2]  = '{2'b00, 4'b1111, 4'b1010};
    vecs[3]  = '{2'b01, 4'b1111, 4'b0101};
    vecs[4]  = '{2'b01, 4'b0000, 4'b0010};
    vecs[5]  = '{2'b01, 4'b1111, 4'b0001};
    vecs[6]  = '{2'b10, 4'b1111, 4'b0010};
    vecs[7]  = '{2'b10, 4'b0000, 4'b0100};
    vecs[8]  = '{2'b10, 4'b1111, 4'b1000};
    vecs[9]  = '{2'b10, 4'b1111, 4'b0000};
    vecs[10] = '{2'b10, 4'b1111, 4'b0000};
    vecs[11] = '{2'b11, 4'b0110, 4'b0110};
    vecs[12] = '{2'b10, 4'b0000, 4'b1100};
    vecs[13] = '{2'b01, 4'b1111, 4'b0110};
    vecs[14] = '{2'b01, 4'b1111, 4'b0011};
    vecs[15] = '{2'b11, 4'b1001, 4'b1001};

    exp8[0] = 8'h00; exp8[1] = 8'h80; exp8[2] = 8'hC0; exp8[3] = 8'hE0;
    exp8[4] = 8'hC1; exp8[5] = 8'h83; exp8[6] = 8'h07; exp8[7] = 8'h0F;
    exp8[8] = 8'h1F; exp8[9] = 8'h3F; exp8[10] = 8'h7F; exp8[11] = 8'hFF;

    #2;
    check("reset4_initial", {4'h0, q4}, 8'h00);
    check("reset8_initial", q8, 8'h00);
    @(negedge clk);
    rst4 = 1'b1;
    rst8 = 1'b1;

    for (int k = 0; k < 16; k++) begin
      step4(vecs[k].mode, vecs[k].din);
      check($sformatf("vec%0d", k), {4'h0, q4}, {4'h0, vecs[k].exp});
    end

    // Async reset mid-cycle from 1010, then held low across edges with load requested.
    step4(2'b11, 4'b1010);
    check("preload_1010", {4'h0, q4}, 8'h0A);
    #2 rst4 = 1'b0;
    #1;
    check("async_reset_midcycle", {4'h0, q4}, 8'h00);
    step4(2'b11, 4'b1111);
    check("reset_hold_edge1", {4'h0, q4}, 8'h00);
    step4(2'b11, 4'b1111);
    check("reset_hold_edge2", {4'h0, q4}, 8'h00);
    @(negedge clk);
    rst4 = 1'b1;

    // Reset pulse during a left shift from 1000 discards the shift.
    step4(2'b11, 4'b1000);
    check("preload_1000", {4'h0, q4}, 8'h08);
    @(negedge clk);
    {s1_4, s0_4} = 2'b10;
    #1 rst4 = 1'b0;
    #1;
    check("reset_during_shift", {4'h0, q4}, 8'h00);
    #1 rst4 = 1'b1;
    step4(2'b00, 4'b0101);
    check("post_reset_hold1", {4'h0, q4}, 8'h00);
    step4(2'b00, 4'b0101);
    check("post_reset_hold2", {4'h0, q4}, 8'h00);
    step4(2'b11, 4'b0101);
    check("post_reset_load", {4'h0, q4}, 8'h05);

    // Wide instance with fill 1: load zero, shift right 3, shift left 8, then one extra left.
    step8(2'b11, 8'h00);
    check("w8_load", q8, exp8[0]);
    for (int k = 1; k <= 3; k++) begin
      step8(2'b01, 8'h55);
      check($sformatf("w8_shr%0d", k), q8, exp8[k]);
    end
    for (int k = 4; k <= 11; k++) begin
      step8(2'b10, 8'h55);
      check($sformatf("w8_shl%0d", k - 3), q8, exp8[k]);
    end
    step8(2'b10, 8'h00);
    check("w8_shl_saturate", q8, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
